// File: rtl/inst_sequencer_if.sv
// Bundles the instruction-offer handshake with the operand, ALU, result and status
// buses of the instruction sequencer. The slave view belongs to the sequencer.
interface inst_sequencer_if;
   logic        in_valid;
   logic [19:0] in_instr;
   logic        in_ready;
   logic        run;
   logic [4:0]  op_addr_a;
   logic [4:0]  op_addr_b;
   logic        op_we;
   logic [2:0]  alu_sel;
   logic [31:0] alu_r;
   logic        alu_zf;
   logic [4:0]  res_addr;
   logic [31:0] res_data;
   logic        res_we;
   logic        busy;
   logic        done;
   logic        zf;
   logic [7:0]  retired;

   modport slave (
      input  in_valid, in_instr, run, alu_r, alu_zf,
      output in_ready, op_addr_a, op_addr_b, op_we, alu_sel,
             res_addr, res_data, res_we, busy, done, zf, retired
   );

   modport master (
      output in_valid, in_instr, run, alu_r, alu_zf,
      input  in_ready, op_addr_a, op_addr_b, op_we, alu_sel,
             res_addr, res_data, res_we, busy, done, zf, retired
   );
endinterface

// File: rtl/inst_sequencer.sv
// Instruction sequencer: a small instruction FIFO feeding an IDLE/FETCH/EXEC/WRITE
// machine that drives operand reads, the ALU select and an optional result write-back.
module inst_sequencer #(
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   inst_sequencer_if.slave bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, FETCH, EXEC, WRITE} state_t;

   logic [19:0]   fifo_mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;

   state_t        state_reg;
   logic [19:0]   ir_reg;
   logic [31:0]   result_reg;
   logic          zf_reg;
   logic          op_we_reg;
   logic          res_we_reg;
   logic          done_reg;
   logic          busy_reg;
   logic [7:0]    retired_reg;

   assign full  = (count_reg == (AW+1)'(DEPTH));
   assign empty = (count_reg == '0);
   // Fullness is judged at the start of the cycle, so a push still fits alongside a pop only when not full.
   assign push  = bus.in_valid && !full;
   assign pop   = (state_reg == FETCH);

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= bus.in_instr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Strobes are set one edge ahead so they are registered while their state is current.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         ir_reg      <= '0;
         result_reg  <= '0;
         zf_reg      <= 1'b0;
         op_we_reg   <= 1'b0;
         res_we_reg  <= 1'b0;
         done_reg    <= 1'b0;
         busy_reg    <= 1'b0;
         retired_reg <= '0;
      end else begin
         if (done_reg) begin
            retired_reg <= retired_reg + 8'd1;
         end
         case (state_reg)
            IDLE: begin
               op_we_reg  <= 1'b0;
               res_we_reg <= 1'b0;
               done_reg   <= 1'b0;
               if (bus.run && !empty) begin
                  state_reg <= FETCH;
                  busy_reg  <= 1'b1;
               end else begin
                  busy_reg  <= 1'b0;
               end
            end
            FETCH: begin
               ir_reg     <= fifo_mem[rd_ptr_reg];
               op_we_reg  <= fifo_mem[rd_ptr_reg][19];
               done_reg   <= !fifo_mem[rd_ptr_reg][18];
               res_we_reg <= 1'b0;
               busy_reg   <= 1'b1;
               state_reg  <= EXEC;
            end
            EXEC: begin
               result_reg <= bus.alu_r;
               zf_reg     <= bus.alu_zf;
               op_we_reg  <= 1'b0;
               if (ir_reg[18]) begin
                  state_reg  <= WRITE;
                  res_we_reg <= 1'b1;
                  done_reg   <= 1'b1;
                  busy_reg   <= 1'b1;
               end else begin
                  state_reg  <= IDLE;
                  res_we_reg <= 1'b0;
                  done_reg   <= 1'b0;
                  busy_reg   <= 1'b0;
               end
            end
            default: begin
               state_reg  <= IDLE;
               op_we_reg  <= 1'b0;
               res_we_reg <= 1'b0;
               done_reg   <= 1'b0;
               busy_reg   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = !full;
   assign bus.op_addr_a = ir_reg[14:10];
   assign bus.op_addr_b = ir_reg[9:5];
   assign bus.alu_sel   = ir_reg[17:15];
   assign bus.res_addr  = ir_reg[4:0];
   assign bus.res_data  = result_reg;
   assign bus.op_we     = op_we_reg;
   assign bus.res_we    = res_we_reg;
   assign bus.done      = done_reg;
   assign bus.busy      = busy_reg;
   assign bus.zf        = zf_reg;
   assign bus.retired   = retired_reg;
endmodule

// File: tb/tb_inst_sequencer.sv
// Bench for inst_sequencer: a cycles-since-pop model checks every output each cycle,
// while directed scenarios pin the model with hand-computed literal expectations.
module tb_inst_sequencer;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   inst_sequencer_if sif();

   inst_sequencer #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (sif)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: instruction queue plus the number of cycles since the current instruction was popped.
   logic [19:0] m_q[$];
   logic [19:0] m_ir;
   logic [31:0] m_res;
   logic        m_zf;
   logic [7:0]  m_ret;
   int          m_phase;
   bit          m_valid = 1'b0;

   initial begin : model_compare
      logic        s_rst, s_v, s_run, s_z;
      logic [19:0] s_i;
      logic [31:0] s_r;
      bit          pushed, was_done;
      forever begin
         @(posedge clk);
         s_rst = rst; s_v = sif.in_valid; s_i = sif.in_instr;
         s_run = sif.run; s_r = sif.alu_r; s_z = sif.alu_zf;
         #1;
         if (s_rst) begin
            m_q.delete();
            m_ir = '0; m_res = '0; m_zf = 1'b0; m_ret = '0; m_phase = -1;
            m_valid = 1'b1;
         end else if (m_valid) begin
            pushed   = s_v && (m_q.size() < DEPTH);
            was_done = (m_phase == 1 && !m_ir[18]) || (m_phase == 2);
            if (was_done) m_ret = m_ret + 8'd1;
            case (m_phase)
               -1: if (s_run && m_q.size() > 0) m_phase = 0;
               0: begin m_ir = m_q.pop_front(); m_phase = 1; end
               1: begin m_res = s_r; m_zf = s_z; m_phase = m_ir[18] ? 2 : -1; end
               default: m_phase = -1;
            endcase
            if (pushed) m_q.push_back(s_i);
         end
         if (m_valid) begin
            check("in_ready",  32'(sif.in_ready),  32'(m_q.size() < DEPTH));
            check("busy",      32'(sif.busy),      32'(m_phase >= 0));
            check("done",      32'(sif.done),      32'((m_phase == 1 && !m_ir[18]) || m_phase == 2));
            check("op_we",     32'(sif.op_we),     32'(m_phase == 1 && m_ir[19]));
            check("res_we",    32'(sif.res_we),    32'(m_phase == 2));
            check("op_addr_a", 32'(sif.op_addr_a), 32'(m_ir[14:10]));
            check("op_addr_b", 32'(sif.op_addr_b), 32'(m_ir[9:5]));
            check("alu_sel",   32'(sif.alu_sel),   32'(m_ir[17:15]));
            check("res_addr",  32'(sif.res_addr),  32'(m_ir[4:0]));
            check("res_data",  sif.res_data,       m_res);
            check("zf",        32'(sif.zf),        32'(m_zf));
            check("retired",   32'(sif.retired),   32'(m_ret));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Pushes n words as fast as the FIFO allows, then waits until the machine has gone quiet.
   task automatic push_and_drain(input int n, input string tag);
      int  left = n;
      int  idle_cnt = 0;
      bit  ok = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (left > 0 && sif.in_ready) begin
            sif.in_valid = 1'b1;
            sif.in_instr = 20'($urandom);
            left--;
         end else begin
            sif.in_valid = 1'b0;
         end
         sif.alu_r  = $urandom;
         sif.alu_zf = 1'($urandom);
         step();
         if (left == 0 && !sif.in_valid && !sif.busy) idle_cnt++;
         else idle_cnt = 0;
         if (idle_cnt >= 2) begin ok = 1'b1; break; end
      end
      sif.in_valid = 1'b0;
      check({tag, "_drain_timeout"}, 32'(ok), 32'd1);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin : stimulus
      logic [31:0] busy_cnt, we_cnt, done_cnt;
      rst = 1'b1;
      sif.in_valid = 1'b0; sif.in_instr = '0; sif.run = 1'b0;
      sif.alu_r = '0; sif.alu_zf = 1'b0;
      repeat (2) step();
      check("rst_in_ready", 32'(sif.in_ready), 32'd1);
      check("rst_busy",     32'(sif.busy),     32'd0);
      check("rst_retired",  32'(sif.retired),  32'd0);
      check("rst_res_data", sif.res_data,      32'd0);
      rst = 1'b0;
      step();
      $display("reset: in_ready=%0b busy=%0b retired=%0d", sif.in_ready, sif.busy, sif.retired);

      // Single write-back instruction; the word's A field decodes to 10, B to 5, R to 3.
      sif.run = 1'b1; sif.alu_r = 32'h12; sif.alu_zf = 1'b0;
      sif.in_valid = 1'b1; sif.in_instr = 20'h4A8A3;
      step();
      sif.in_valid = 1'b0;
      step(); check("wb_res_we_c1", 32'(sif.res_we), 32'd0);
      step(); check("wb_res_we_c2", 32'(sif.res_we), 32'd0);
      check("wb_op_addr_a", 32'(sif.op_addr_a), 32'd10);
      check("wb_op_addr_b", 32'(sif.op_addr_b), 32'd5);
      check("wb_alu_sel",   32'(sif.alu_sel),   32'd1);
      step(); check("wb_res_we_c3", 32'(sif.res_we), 32'd1);
      check("wb_res_addr", 32'(sif.res_addr), 32'd3);
      check("wb_res_data", sif.res_data,      32'h12);
      step(); check("wb_res_we_c4", 32'(sif.res_we), 32'd0);
      check("wb_retired", 32'(sif.retired), 32'd1);
      $display("writeback: res_addr=%0d res_data=0x%0h retired=%0d", sif.res_addr, sif.res_data, sif.retired);

      // Overfill with run low, then release and count completions.
      sif.run = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         sif.in_valid = 1'b1; sif.in_instr = 20'($urandom);
         step();
         if (i == DEPTH - 1) check("fill_in_ready", 32'(sif.in_ready), 32'd0);
      end
      sif.in_valid = 1'b0;
      check("fill_busy", 32'(sif.busy), 32'd0);
      sif.run = 1'b1;
      done_cnt = 0;
      for (int c = 0; c < 6 * DEPTH + 10; c++) begin
         sif.alu_r = $urandom; sif.alu_zf = 1'($urandom);
         step();
         done_cnt += 32'(sif.done);
      end
      check("fill_done_count", done_cnt, 32'(DEPTH));
      $display("overfill: done pulses=%0d", done_cnt);

      // No-write-back instruction with the zero flag set.
      sif.alu_zf = 1'b1; sif.alu_r = $urandom;
      sif.in_valid = 1'b1; sif.in_instr = 20'h81234;
      step();
      sif.in_valid = 1'b0;
      busy_cnt = 0; we_cnt = 0;
      for (int k = 1; k <= 5; k++) begin
         step();
         busy_cnt += 32'(sif.busy);
         we_cnt   += 32'(sif.res_we);
         if (k == 2) begin
            check("nowb_done_exec", 32'(sif.done),  32'd1);
            check("nowb_op_we",     32'(sif.op_we), 32'd1);
         end
         if (k == 3) check("nowb_zf", 32'(sif.zf), 32'd1);
      end
      check("nowb_busy_cycles", busy_cnt, 32'd2);
      check("nowb_res_we_count", we_cnt, 32'd0);
      sif.alu_zf = 1'b0;
      $display("no-writeback: busy cycles=%0d res_we pulses=%0d", busy_cnt, we_cnt);

      // Reset while a write-back instruction is in EXEC, with another word still queued.
      rst = 1'b1; step(); rst = 1'b0;
      sif.in_valid = 1'b1; sif.in_instr = 20'h40000 | 20'($urandom_range(0, 32'h3FFFF));
      step();
      sif.in_instr = 20'h40000 | 20'($urandom_range(0, 32'h3FFFF));
      step();
      sif.in_valid = 1'b0;
      step();
      check("abort_busy_exec", 32'(sif.busy), 32'd1);
      rst = 1'b1; step(); rst = 1'b0;
      busy_cnt = 0; we_cnt = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         busy_cnt += 32'(sif.busy);
         we_cnt   += 32'(sif.res_we);
      end
      check("abort_res_we", we_cnt, 32'd0);
      check("abort_busy", busy_cnt, 32'd0);
      check("abort_retired", 32'(sif.retired), 32'd0);
      check("abort_in_ready", 32'(sif.in_ready), 32'd1);
      $display("abort: res_we pulses=%0d busy cycles=%0d retired=%0d", we_cnt, busy_cnt, sif.retired);

      // Random traffic with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         sif.in_valid = 1'($urandom);
         sif.in_instr = 20'($urandom);
         sif.run      = ($urandom_range(0, 7) != 0);
         sif.alu_r    = $urandom;
         sif.alu_zf   = 1'($urandom);
         rst          = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0; sif.in_valid = 1'b0; sif.run = 1'b1;
      $display("random: 3000 cycles applied");

      // Retired counter wrap.
      rst = 1'b1; step(); rst = 1'b0;
      push_and_drain(255, "wrap255");
      check("wrap_retired_255", 32'(sif.retired), 32'd255);
      push_and_drain(1, "wrap256");
      check("wrap_retired_0", 32'(sif.retired), 32'd0);
      $display("wrap: retired=%0d", sif.retired);

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
